// File: rtl/bomb_countdown_timer_if.sv
// Control/status bundle of the bomb countdown core: load/start/defuse inputs
// and the BCD time, tries and cue/flag outputs.
interface bomb_countdown_timer_if;
  logic        load;
  logic [3:0]  load_min;
  logic [6:0]  load_sec;
  logic        start;
  logic [15:0] code_in;
  logic        code_valid;
  logic [3:0]  min_bcd;
  logic [6:0]  sec_bcd;
  logic [2:0]  tries_left;
  logic        sec;
  logic        LSB;
  logic        u10;
  logic        bomb;
  logic        defused;

  modport master (
    output load, load_min, load_sec, start, code_in, code_valid,
    input  min_bcd, sec_bcd, tries_left, sec, LSB, u10, bomb, defused
  );

  modport slave (
    input  load, load_min, load_sec, start, code_in, code_valid,
    output min_bcd, sec_bcd, tries_left, sec, LSB, u10, bomb, defused
  );
endinterface

// File: rtl/bomb_countdown_timer.sv
// Game countdown core: counts M:SS down in BCD once armed, evaluates defuse
// codes and raises sticky bomb/defused flags plus sec/LSB/u10 beep cues.
module bomb_countdown_timer #(
  parameter int unsigned TICK_DIV  = 1000,
  parameter int unsigned INIT_MIN  = 3,
  parameter int unsigned INIT_SEC  = 0,
  parameter logic [15:0] CODE      = 16'h1234,
  parameter int unsigned MAX_TRIES = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  bomb_countdown_timer_if.slave  bus
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_ARMED    = 2'd1;
  localparam logic [1:0] S_DEFUSED  = 2'd2;
  localparam logic [1:0] S_EXPLODED = 2'd3;

  localparam int unsigned PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0] P_LAST   = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] P_HALF   = PW'(TICK_DIV / 2);
  localparam logic [3:0] INIT_M      = 4'(INIT_MIN);
  localparam logic [2:0] INIT_T      = 3'(INIT_SEC / 10);
  localparam logic [3:0] INIT_U      = 4'(INIT_SEC % 10);
  localparam logic [2:0] INIT_TRIES  = 3'(MAX_TRIES);

  logic [1:0]    state_q, state_d;
  logic [3:0]    min_q, min_d;
  logic [2:0]    tens_q, tens_d;
  logic [3:0]    units_q, units_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    tries_q, tries_d;
  logic          bomb_q, bomb_d;
  logic          defused_q, defused_d;

  logic          tick;
  logic          time_zero;
  logic          dec_zero;
  logic          load_ok;
  logic          code_ok;
  logic [3:0]    dec_min;
  logic [2:0]    dec_tens;
  logic [3:0]    dec_units;

  // One-second BCD decrement with borrow across units, tens and minutes
  always_comb begin
    dec_min   = min_q;
    dec_tens  = tens_q;
    dec_units = units_q;
    if (units_q != 4'd0) begin
      dec_units = units_q - 4'd1;
    end else begin
      dec_units = 4'd9;
      if (tens_q != 3'd0) begin
        dec_tens = tens_q - 3'd1;
      end else begin
        dec_tens = 3'd5;
        dec_min  = min_q - 4'd1;
      end
    end
  end

  assign tick      = (state_q == S_ARMED) && (presc_q == P_LAST);
  assign time_zero = (min_q == 4'd0) && (tens_q == 3'd0) && (units_q == 4'd0);
  assign dec_zero  = (min_q == 4'd0) && (tens_q == 3'd0) && (units_q == 4'd1);
  assign load_ok   = (bus.load_min <= 4'd9) && (bus.load_sec[6:4] <= 3'd5) &&
                     (bus.load_sec[3:0] <= 4'd9);
  assign code_ok   = bus.code_valid && (bus.code_in == CODE);

  // Next-state: FSM, time, prescaler, tries and sticky flags
  always_comb begin
    state_d   = state_q;
    min_d     = min_q;
    tens_d    = tens_q;
    units_d   = units_q;
    presc_d   = '0;
    tries_d   = tries_q;
    bomb_d    = bomb_q;
    defused_d = defused_q;
    case (state_q)
      S_IDLE: begin
        if (bus.load && load_ok) begin
          min_d   = bus.load_min;
          tens_d  = bus.load_sec[6:4];
          units_d = bus.load_sec[3:0];
        end
        if (bus.start && !time_zero) begin
          state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        // A correct code beats a coincident final decrement; time is not
        // decremented on that edge.
        if (code_ok) begin
          state_d   = S_DEFUSED;
          defused_d = 1'b1;
          presc_d   = '0;
        end else begin
          if (tick && !time_zero) begin
            min_d   = dec_min;
            tens_d  = dec_tens;
            units_d = dec_units;
          end
          if (bus.code_valid) begin
            tries_d = (tries_q == 3'd0) ? 3'd0 : tries_q - 3'd1;
          end
          if ((tick && dec_zero) || (bus.code_valid && tries_q == 3'd1)) begin
            state_d = S_EXPLODED;
            bomb_d  = 1'b1;
            presc_d = '0;
          end
        end
      end
      default: begin
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      min_q     <= INIT_M;
      tens_q    <= INIT_T;
      units_q   <= INIT_U;
      presc_q   <= '0;
      tries_q   <= INIT_TRIES;
      bomb_q    <= 1'b0;
      defused_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      min_q     <= min_d;
      tens_q    <= tens_d;
      units_q   <= units_d;
      presc_q   <= presc_d;
      tries_q   <= tries_d;
      bomb_q    <= bomb_d;
      defused_q <= defused_d;
    end
  end

  assign bus.min_bcd    = min_q;
  assign bus.sec_bcd    = {tens_q, units_q};
  assign bus.tries_left = tries_q;
  assign bus.sec        = (state_q == S_ARMED) && (presc_q < P_HALF);
  assign bus.LSB        = units_q[0];
  assign bus.u10        = (state_q == S_ARMED) && (min_q == 4'd0) && (tens_q == 3'd0);
  assign bus.bomb       = bomb_q;
  assign bus.defused    = defused_q;

endmodule

// File: tb/tb_bomb_countdown_timer.sv
// Randomized bench for bomb_countdown_timer against a seconds-based model.
module tb_bomb_countdown_timer;
  localparam int TD = 10;
  localparam int INIT_T = 180;
  localparam logic [15:0] GOOD = 16'h1234;
  localparam int M_IDLE = 0, M_ARMED = 1, M_DEF = 2, M_EXP = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bomb_countdown_timer_if bus();

  bomb_countdown_timer #(
    .TICK_DIV(TD), .INIT_MIN(3), .INIT_SEC(0), .CODE(GOOD), .MAX_TRIES(3)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;

  // model: remaining time in plain seconds, phase within the current second
  int m_st, m_time, m_ph, m_tries;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model(input bit r, input bit ld, input logic [3:0] lm, input logic [6:0] ls,
                       input bit st, input logic [15:0] cd, input bit cv);
    int t0;
    bit tk;
    int old;
    if (r) begin
      m_st = M_IDLE; m_time = INIT_T; m_ph = 0; m_tries = 3;
      return;
    end
    case (m_st)
      M_IDLE: begin
        t0 = m_time;
        if (ld && lm <= 9 && ls[6:4] <= 5 && ls[3:0] <= 9)
          m_time = int'(lm) * 60 + int'(ls[6:4]) * 10 + int'(ls[3:0]);
        if (st && t0 != 0) begin
          m_st = M_ARMED; m_ph = 0;
        end
      end
      M_ARMED: begin
        tk = (m_ph == TD - 1);
        m_ph = (m_ph + 1) % TD;
        if (cv && cd == GOOD) begin
          m_st = M_DEF; m_ph = 0;
        end else begin
          old = m_tries;
          if (tk && m_time > 0) m_time--;
          if (cv && m_tries > 0) m_tries--;
          if ((tk && m_time == 0) || (cv && old == 1)) begin
            m_st = M_EXP; m_ph = 0;
          end
        end
      end
      default: ;
    endcase
  endtask

  task automatic compare_all();
    check("min", 32'(bus.min_bcd), 32'(m_time / 60));
    check("sec_bcd", 32'(bus.sec_bcd), 32'(((m_time % 60) / 10) * 16 + (m_time % 10)));
    check("tries", 32'(bus.tries_left), 32'(m_tries));
    check("sec", 32'(bus.sec), 32'(m_st == M_ARMED && m_ph < TD / 2));
    check("LSB", 32'(bus.LSB), 32'((m_time % 10) % 2));
    check("u10", 32'(bus.u10), 32'(m_st == M_ARMED && m_time < 10));
    check("bomb", 32'(bus.bomb), 32'(m_st == M_EXP));
    check("defused", 32'(bus.defused), 32'(m_st == M_DEF));
  endtask

  // Drive one cycle of inputs at the falling edge, advance model at the
  // rising edge, compare at the next falling edge.
  task automatic cycle(input bit r, input bit ld, input logic [3:0] lm, input logic [6:0] ls,
                       input bit st, input logic [15:0] cd, input bit cv);
    rst = r; bus.load = ld; bus.load_min = lm; bus.load_sec = ls;
    bus.start = st; bus.code_in = cd; bus.code_valid = cv;
    @(posedge clk);
    model(r, ld, lm, ls, st, cd, cv);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 4'd0, 7'd0, 1'b0, 16'h0, 1'b0);
  endtask

  initial begin
    logic [3:0] lm;
    logic [2:0] lt;
    logic [3:0] lu;
    logic [15:0] cd;
    int term_cnt, idle_cnt;
    bus.load = 0; bus.load_min = 0; bus.load_sec = 0; bus.start = 0;
    bus.code_in = 0; bus.code_valid = 0;
    @(negedge clk);
    cycle(1'b1, 1'b0, 4'd0, 7'd0, 1'b0, 16'h0, 1'b0);

    // correct code on the final-decrement edge, then a malformed load
    cycle(1'b0, 1'b1, 4'd0, 7'h01, 1'b0, 16'h0, 1'b0);
    cycle(1'b0, 1'b0, 4'd0, 7'h00, 1'b1, 16'h0, 1'b0);
    idle(TD - 1);
    cycle(1'b0, 1'b0, 4'd0, 7'd0, 1'b0, GOOD, 1'b1);
    check("t5_defused", 32'(bus.defused), 32'd1);
    check("t5_time", 32'({bus.min_bcd, 1'b0, bus.sec_bcd}), 32'h001);
    idle(3);
    cycle(1'b1, 1'b0, 4'd0, 7'd0, 1'b0, 16'h0, 1'b0);
    cycle(1'b0, 1'b1, 4'd0, 7'h6A, 1'b0, 16'h0, 1'b0);
    check("bad_load", 32'({bus.min_bcd, 1'b0, bus.sec_bcd}), 32'h300);

    // rst while armed
    cycle(1'b0, 1'b0, 4'd0, 7'd0, 1'b1, 16'h0, 1'b0);
    idle(37);
    cycle(1'b1, 1'b0, 4'd0, 7'd0, 1'b0, 16'h0, 1'b0);
    check("rst_mid", 32'({bus.sec, bus.u10, bus.bomb, bus.defused}), 32'd0);

    // randomized scenarios
    for (int s = 0; s < 40; s++) begin
      cycle(1'b1, 1'b0, 4'd0, 7'd0, 1'b0, 16'h0, 1'b0);
      if ($urandom_range(0, 7) != 0) begin
        lm = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 1));
        lt = 3'($urandom_range(0, 7));
        lu = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
        cycle(1'b0, 1'b1, lm, {lt, lu}, 1'b0, 16'h0, 1'b0);
      end
      cycle(1'b0, 1'b0, 4'd0, 7'd0, 1'b1, 16'h0, 1'b0);
      term_cnt = 0;
      idle_cnt = 0;
      for (int c = 0; c < 2000; c++) begin
        cd = ($urandom_range(0, 3) == 0) ? GOOD :
             (($urandom_range(0, 1) == 0) ? 16'h0000 : 16'($urandom));
        cycle(($urandom_range(0, 1999) == 0),
              ($urandom_range(0, 99) == 0), 4'($urandom_range(0, 9)), 7'($urandom_range(0, 89)),
              ($urandom_range(0, 49) == 0), cd, ($urandom_range(0, 79) == 0));
        if (m_st == M_DEF || m_st == M_EXP) term_cnt++;
        if (m_st == M_IDLE) idle_cnt++; else idle_cnt = 0;
        if (term_cnt > 20 || idle_cnt > 200) break;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
